// File: rtl/ibex_fetch_realign.sv
// Fetch-word FIFO and halfword realigner feeding the compressed decoder.
// Emits one 16/32-bit instruction per accept, stitching words that straddle a fetch-word boundary.
module ibex_fetch_realign #(
   parameter int unsigned DEPTH     = 3,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic [31:0] branch_addr_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_rdata_i,
   input  logic        in_err_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_rdata_o,
   output logic [31:0] out_addr_o,
   output logic        out_err_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   typedef struct packed {
      logic        err;
      logic [31:0] word;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt;
   logic [CW-1:0]   count;
   logic [31:0]     addr_q;

   entry_t          w0, w1;
   logic            w0_vld, w1_vld;
   logic [15:0]     hi_half;
   logic            valid_raw, err_raw, pop_sel;
   logic [31:0]     addr_inc;
   logic            push, accept, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign rd_ptr_nxt = ptr_inc(rd_ptr);
   assign w0         = mem[rd_ptr];
   assign w1         = mem[rd_ptr_nxt];
   assign w0_vld     = (count != '0);
   assign w1_vld     = (count >= CW'(2));
   assign hi_half    = w1_vld ? w1.word[15:0] : 16'h0;

   // Instruction select: aligned word, upper-half compressed, or straddling 32-bit.
   always_comb begin
      valid_raw   = 1'b0;
      out_rdata_o = w0.word;
      err_raw     = w0.err;
      pop_sel     = 1'b1;
      addr_inc    = 32'd4;
      if (!addr_q[1]) begin
         valid_raw = w0_vld;
         if (w0.word[1:0] != 2'b11) begin
            pop_sel  = 1'b0;
            addr_inc = 32'd2;
         end
      end else if (w0.word[17:16] != 2'b11) begin
         valid_raw   = w0_vld;
         out_rdata_o = {hi_half, w0.word[31:16]};
         addr_inc    = 32'd2;
      end else begin
         // A faulted first half is reported without waiting for the second word.
         valid_raw   = w0_vld & (w1_vld | w0.err);
         out_rdata_o = {hi_half, w0.word[31:16]};
         err_raw     = w0.err | (w1_vld & w1.err);
      end
   end

   assign in_ready_o  = (count != FULL);
   assign out_valid_o = valid_raw & ~clear_i;
   assign out_err_o   = err_raw & out_valid_o;
   assign out_addr_o  = addr_q;
   assign accept      = out_valid_o & out_ready_i;
   assign pop         = accept & pop_sel;
   assign push        = in_valid_i & in_ready_o & ~clear_i;

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= '{err: in_err_i, word: in_rdata_i};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         addr_q <= BOOT_ADDR;
      end else if (clear_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         addr_q <= {branch_addr_i[31:1], 1'b0};
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= rd_ptr_nxt;
         count <= count + CW'(push) - CW'(pop);
         if (accept) addr_q <= addr_q + addr_inc;
      end
   end

endmodule

// File: tb/tb_ibex_fetch_realign.sv
// Bench for ibex_fetch_realign: directed scenarios plus random traffic against a halfword-stream model.
module tb_ibex_fetch_realign;

   localparam int unsigned DEPTH = 3;
   localparam logic [31:0] BOOT  = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst_i, clear_i, in_valid_i, in_err_i, out_ready_i;
   logic [31:0] branch_addr_i, in_rdata_i;
   logic        in_ready_o, out_valid_o, out_err_o;
   logic [31:0] out_rdata_o, out_addr_o;

   int n_checks = 0;
   int n_pass   = 0;

   ibex_fetch_realign #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .branch_addr_i(branch_addr_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_rdata_i(in_rdata_i),
      .in_err_i(in_err_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_rdata_o(out_rdata_o), .out_addr_o(out_addr_o), .out_err_o(out_err_o)
   );

   always #5 clk = ~clk;

   // Model: the fetched stream as a queue of halfwords, each tagged with its error bit
   // and the fetch word it came from. skip counts leading halfwords still to be discarded.
   logic [15:0] hq_d[$];
   bit          hq_e[$];
   int          hq_id[$];
   int          skip = 0;
   int          next_id = 0;
   logic [31:0] m_addr = BOOT;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < hq_id.size(); i++)
         if (i == 0 || hq_id[i] != hq_id[i-1]) c++;
      return c;
   endfunction

   function automatic bit m_compressed();
      return hq_d[0][1:0] != 2'b11;
   endfunction

   function automatic bit m_valid(input bit clr);
      if (clr || hq_d.size() == 0) return 1'b0;
      if (m_compressed()) return 1'b1;
      return (hq_d.size() >= 2) || hq_e[0];
   endfunction

   function automatic logic [31:0] m_rdata();
      return {(hq_d.size() >= 2) ? hq_d[1] : 16'h0, hq_d[0]};
   endfunction

   function automatic bit m_err();
      if (m_compressed()) return hq_e[0];
      return hq_e[0] | ((hq_d.size() >= 2) && hq_e[1]);
   endfunction

   task automatic m_flush();
      hq_d.delete(); hq_e.delete(); hq_id.delete();
   endtask

   // Advance DUT and model one clock with the inputs currently driven.
   task automatic tick();
      bit v, rdy;
      int n;
      v   = m_valid(clear_i);
      rdy = (m_count() != DEPTH);
      @(posedge clk);
      if (rst_i) begin
         m_flush(); m_addr = BOOT; skip = 0;
      end else if (clear_i) begin
         m_flush(); m_addr = {branch_addr_i[31:1], 1'b0}; skip = int'(branch_addr_i[1]);
      end else begin
         if (v && out_ready_i) begin
            n = m_compressed() ? 1 : 2;
            m_addr = m_addr + 32'(2 * n);
            for (int i = 0; i < n; i++) begin
               if (hq_d.size() > 0) begin
                  void'(hq_d.pop_front()); void'(hq_e.pop_front()); void'(hq_id.pop_front());
               end else skip++;
            end
         end
         if (in_valid_i && rdy) begin
            if (skip > 0) skip--;
            else begin
               hq_d.push_back(in_rdata_i[15:0]); hq_e.push_back(in_err_i); hq_id.push_back(next_id);
            end
            hq_d.push_back(in_rdata_i[31:16]); hq_e.push_back(in_err_i); hq_id.push_back(next_id);
            next_id++;
         end
      end
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      rst_i = 0; clear_i = 0; in_valid_i = 0; in_err_i = 0; out_ready_i = 0;
      branch_addr_i = 32'h0; in_rdata_i = 32'h0;
   endtask

   task automatic redirect(input logic [31:0] a);
      clear_i = 1; branch_addr_i = a; tick(); clear_i = 0;
   endtask

   task automatic test_reset();
      idle(); rst_i = 1; tick(); tick(); rst_i = 0;
      n_checks++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid_o); else n_pass++;
      n_checks++; if (out_err_o !== 1'b0) $display("FAIL reset_err got %b want 0", out_err_o); else n_pass++;
      n_checks++; if (in_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready_o); else n_pass++;
      n_checks++; if (out_addr_o !== 32'h80) $display("FAIL reset_addr got %h want 00000080", out_addr_o); else n_pass++;
   endtask

   task automatic test_compressed_pair();
      in_valid_i = 1; in_rdata_i = 32'h4501_4505; out_ready_i = 1; tick(); in_valid_i = 0;
      n_checks++; if (out_valid_o !== 1'b1 || out_addr_o !== 32'h80 || out_rdata_o[15:0] !== 16'h4505)
         $display("FAIL c_first got v=%b a=%h d=%h want v=1 a=00000080 d=4505", out_valid_o, out_addr_o, out_rdata_o[15:0]); else n_pass++;
      tick();
      n_checks++; if (out_valid_o !== 1'b1 || out_addr_o !== 32'h82 || out_rdata_o[15:0] !== 16'h4501)
         $display("FAIL c_second got v=%b a=%h d=%h want v=1 a=00000082 d=4501", out_valid_o, out_addr_o, out_rdata_o[15:0]); else n_pass++;
      tick();
      n_checks++; if (out_valid_o !== 1'b0 || out_addr_o !== 32'h84 || in_ready_o !== 1'b1)
         $display("FAIL c_drained got v=%b a=%h r=%b want v=0 a=00000084 r=1", out_valid_o, out_addr_o, in_ready_o); else n_pass++;
      out_ready_i = 0;
   endtask

   task automatic test_straddle();
      redirect(32'h102);
      in_valid_i = 1; in_rdata_i = 32'h0513_0001; tick(); in_valid_i = 0;
      n_checks++; if (out_valid_o !== 1'b0) $display("FAIL strad_wait got v=%b want 0", out_valid_o); else n_pass++;
      in_valid_i = 1; in_rdata_i = 32'h0001_0010; tick(); in_valid_i = 0;
      n_checks++; if (out_valid_o !== 1'b1 || out_rdata_o !== 32'h0010_0513 || out_addr_o !== 32'h102)
         $display("FAIL strad_join got v=%b d=%h a=%h want v=1 d=00100513 a=00000102", out_valid_o, out_rdata_o, out_addr_o); else n_pass++;
      out_ready_i = 1; tick();
      n_checks++; if (out_valid_o !== 1'b1 || out_addr_o !== 32'h106 || out_rdata_o[15:0] !== 16'h0001)
         $display("FAIL strad_next got v=%b a=%h d=%h want v=1 a=00000106 d=0001", out_valid_o, out_addr_o, out_rdata_o[15:0]); else n_pass++;
      tick(); out_ready_i = 0;
   endtask

   task automatic test_err_straddle();
      redirect(32'h202);
      in_valid_i = 1; in_err_i = 1; in_rdata_i = 32'h0513_0001; tick(); in_valid_i = 0; in_err_i = 0;
      n_checks++; if (out_valid_o !== 1'b1 || out_err_o !== 1'b1 || out_addr_o !== 32'h202)
         $display("FAIL err_strad got v=%b e=%b a=%h want v=1 e=1 a=00000202", out_valid_o, out_err_o, out_addr_o); else n_pass++;
      out_ready_i = 1; tick(); out_ready_i = 0;
   endtask

   task automatic test_full();
      redirect(32'h300);
      in_valid_i = 1; in_rdata_i = 32'h0000_0013;
      for (int i = 0; i < DEPTH; i++) tick();
      in_valid_i = 0;
      n_checks++; if (in_ready_o !== 1'b0) $display("FAIL full_ready got %b want 0", in_ready_o); else n_pass++;
      out_ready_i = 1; tick(); out_ready_i = 0;
      n_checks++; if (in_ready_o !== 1'b1 || out_addr_o !== 32'h304)
         $display("FAIL full_pop got r=%b a=%h want r=1 a=00000304", in_ready_o, out_addr_o); else n_pass++;
   endtask

   task automatic test_clear_pending();
      clear_i = 1; branch_addr_i = 32'h500; in_valid_i = 1; in_rdata_i = 32'hDEAD_BEEF; out_ready_i = 1;
      #1;
      n_checks++; if (out_valid_o !== 1'b0) $display("FAIL clr_same got v=%b want 0", out_valid_o); else n_pass++;
      tick(); clear_i = 0; in_valid_i = 0; out_ready_i = 0;
      n_checks++; if (out_valid_o !== 1'b0 || out_addr_o !== 32'h500 || in_ready_o !== 1'b1)
         $display("FAIL clr_next got v=%b a=%h r=%b want v=0 a=00000500 r=1", out_valid_o, out_addr_o, in_ready_o); else n_pass++;
      in_valid_i = 1; in_rdata_i = 32'h0000_0013; tick(); in_valid_i = 0;
      n_checks++; if (out_valid_o !== 1'b1 || out_rdata_o !== 32'h0000_0013)
         $display("FAIL clr_fresh got v=%b d=%h want v=1 d=00000013", out_valid_o, out_rdata_o); else n_pass++;
   endtask

   task automatic test_rst_mid();
      redirect(32'h402);
      in_valid_i = 1; in_rdata_i = 32'h0003_0000; tick(); in_valid_i = 0;
      n_checks++; if (out_valid_o !== 1'b0) $display("FAIL rst_hold got v=%b want 0", out_valid_o); else n_pass++;
      rst_i = 1; tick(); rst_i = 0;
      n_checks++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_addr_o !== 32'h80)
         $display("FAIL rst_mid got v=%b r=%b a=%h want v=0 r=1 a=00000080", out_valid_o, in_ready_o, out_addr_o); else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] w;
      bit ev;
      for (int c = 0; c < 4000; c++) begin
         w = $urandom;
         if ($urandom_range(1) == 1) w[1:0] = 2'b11;
         if ($urandom_range(1) == 1) w[17:16] = 2'b11;
         rst_i         = ($urandom_range(499) == 0);
         clear_i       = ($urandom_range(49) == 0);
         branch_addr_i = $urandom;
         in_valid_i    = ($urandom_range(9) < 7);
         in_rdata_i    = w;
         in_err_i      = ($urandom_range(15) == 0);
         out_ready_i   = ($urandom_range(9) < 7);
         #1;
         ev = m_valid(clear_i);
         n_checks++; if (out_valid_o !== ev || out_addr_o !== m_addr || in_ready_o !== (m_count() != DEPTH))
            $display("FAIL rnd_ctrl cyc %0d got v=%b a=%h r=%b want v=%b a=%h r=%b", c, out_valid_o, out_addr_o,
                     in_ready_o, ev, m_addr, m_count() != DEPTH); else n_pass++;
         if (ev) begin
            n_checks++; if (out_rdata_o !== m_rdata() || out_err_o !== m_err())
               $display("FAIL rnd_data cyc %0d got d=%h e=%b want d=%h e=%b", c, out_rdata_o, out_err_o,
                        m_rdata(), m_err()); else n_pass++;
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_compressed_pair();
      test_straddle();
      test_err_straddle();
      test_full();
      test_clear_pending();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
